// File: rtl/la_wb_master.sv
// Bridges toggle-handshaked logic-analyzer probe writes into single Wishbone
// master cycles, with a bounded wait for ack so a hung slave cannot wedge the LA path.
module la_wb_master #(
  parameter int                   ADR_WIDTH      = 32,
  parameter int                   DAT_WIDTH      = 32,
  parameter int                   TIMEOUT_CYCLES = 255,
  parameter logic [DAT_WIDTH-1:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   la_req,
  input  logic                   la_we,
  input  logic [DAT_WIDTH/8-1:0] la_sel,
  input  logic [ADR_WIDTH-1:0]   la_adr,
  input  logic [DAT_WIDTH-1:0]   la_dat_w,
  output logic                   la_ack,
  output logic                   la_err,
  output logic [DAT_WIDTH-1:0]   la_dat_r,
  output logic                   busy,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [DAT_WIDTH/8-1:0] wb_sel_o,
  output logic [ADR_WIDTH-1:0]   wb_adr_o,
  output logic [DAT_WIDTH-1:0]   wb_dat_o,
  input  logic                   wb_ack_i,
  input  logic [DAT_WIDTH-1:0]   wb_dat_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LATCH, BUS} state_t;

  state_t        state;
  logic          req_meta;
  logic          req_s;
  logic          req_seen;
  logic          cyc;
  logic [CW-1:0] counter;

  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      req_meta <= 1'b0;
      req_s    <= 1'b0;
      req_seen <= 1'b0;
      cyc      <= 1'b0;
      counter  <= '0;
      la_ack   <= 1'b0;
      la_err   <= 1'b0;
      la_dat_r <= '0;
      busy     <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      req_meta <= la_req;
      req_s    <= req_meta;
      case (state)
        IDLE: begin
          // Any level difference is a request; toggles while busy collapse pairwise.
          if (req_s != req_seen) begin
            req_seen <= req_s;
            busy     <= 1'b1;
            state    <= LATCH;
          end
        end
        LATCH: begin
          wb_we_o  <= la_we;
          wb_sel_o <= la_sel;
          wb_adr_o <= la_adr;
          wb_dat_o <= la_dat_w;
          cyc      <= 1'b1;
          counter  <= '0;
          state    <= BUS;
        end
        BUS: begin
          if (wb_ack_i) begin
            la_dat_r <= wb_dat_i;
            la_err   <= 1'b0;
            cyc      <= 1'b0;
            la_ack   <= ~la_ack;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (counter == CNT_LAST) begin
            la_dat_r <= ERR_DATA;
            la_err   <= 1'b1;
            cyc      <= 1'b0;
            la_ack   <= ~la_ack;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
